// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, ALU/immediate encodings and the decoded-control bundle.
package rv32i_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 6;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
    typedef struct packed {
        logic    rd_we;
        logic    alu_src_imm;
        logic    mem_rd;
        logic    mem_wr;
        logic    branch;
        logic    jump;
        logic    illegal;
        alu_op_e alu_op;
    } ctrl_t;
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
    // BEQ/BNE compare by subtraction, BLT/BGE signed, BLTU/BGEU unsigned
    function automatic alu_op_e alu_branch(input logic [2:0] f3);
        return f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended RV32I immediate for the I/S/B/U/J formats.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7]     instr_i,
    input  logic [2:0]      fmt_i,
    output logic [XLEN-1:0] imm_o
);
    always_comb begin
        imm_o = fmt_i == IMM_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
                fmt_i == IMM_B ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
                fmt_i == IMM_U ? {instr_i[31:12], 12'b0} :
                fmt_i == IMM_J ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
                                 {{20{instr_i[31]}}, instr_i[31:20]};
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with regfile bypass, load-use bubble and ID/EX register.
// Define DECODE_ILLEGAL_TRAP_EN to flag illegal instructions instead of decoding them as NOPs.
module decode_stage
    import rv32i_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_instr,
    input  logic [31:0]           if_pc,
    output logic [REG_ADDR_W-1:0] Read_Reg1,
    output logic [REG_ADDR_W-1:0] Read_Reg2,
    input  logic [XLEN-1:0]       Read_Data1,
    input  logic [XLEN-1:0]       Read_Data2,
    input  logic                  wb_write,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [XLEN-1:0]       id_pc,
    output logic [XLEN-1:0]       id_rs1_val,
    output logic [XLEN-1:0]       id_rs2_val,
    output logic [XLEN-1:0]       id_imm,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic                  id_rd_we,
    output logic                  id_alu_src_imm,
    output logic                  id_mem_rd,
    output logic                  id_mem_wr,
    output logic                  id_branch,
    output logic                  id_jump,
    output logic                  id_illegal,
    output logic [3:0]            id_alu_op,
    output logic [2:0]            id_funct3
);
    logic [6:0] opc;
    logic [2:0] f3;
    ctrl_t ctrl_d, ctrl_q;
    imm_fmt_e fmt;
    logic uses_rs1, uses_rs2, ld, haz, capture;
    logic [XLEN-1:0] imm_d, rs1_d, rs2_d;
    logic id_valid_q;
    logic [XLEN-1:0] id_pc_q, id_rs1_q, id_rs2_q, id_imm_q;
    logic [REG_ADDR_W-1:0] id_rd_q;
    logic [2:0] id_funct3_q;

    assign opc       = if_instr[6:0];
    assign f3        = if_instr[14:12];
    assign Read_Reg1 = {1'b0, if_instr[19:15]};
    assign Read_Reg2 = {1'b0, if_instr[24:20]};

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal;
    assign illegal = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                   OPC_STORE, OPC_OPIMM, OPC_OP, OPC_MISCMEM, OPC_SYSTEM}) |
                     (opc == OPC_OP && !(if_instr[31:25] inside {7'h00, 7'h20}));
`endif

    always_comb begin
        ctrl_d   = '0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        fmt      = IMM_I;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_src_imm = 1'b1; uses_rs1 = 1'b0; fmt = IMM_U;
            end
            OPC_JAL: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_src_imm = 1'b1; ctrl_d.jump = 1'b1; uses_rs1 = 1'b0; fmt = IMM_J;
            end
            OPC_JALR: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_src_imm = 1'b1; ctrl_d.jump = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1; ctrl_d.alu_op = alu_branch(f3); uses_rs2 = 1'b1; fmt = IMM_B;
            end
            OPC_LOAD: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_src_imm = 1'b1; ctrl_d.mem_rd = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.alu_src_imm = 1'b1; ctrl_d.mem_wr = 1'b1; uses_rs2 = 1'b1; fmt = IMM_S;
            end
            OPC_OPIMM: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                ctrl_d.alu_op = alu_from_f3(f3, f3 == 3'b101 && if_instr[30]);
            end
            OPC_OP: begin
                ctrl_d.rd_we = 1'b1; ctrl_d.alu_op = alu_from_f3(f3, if_instr[30]); uses_rs2 = 1'b1;
            end
            default: ;
        endcase
        if (if_instr[11:7] == 5'd0) ctrl_d.rd_we = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        ctrl_d.illegal = illegal;
        if (illegal) begin
            ctrl_d.rd_we  = 1'b0;
            ctrl_d.mem_rd = 1'b0;
            ctrl_d.mem_wr = 1'b0;
        end
`endif
    end

    imm_gen u_imm_gen (
        .instr_i (if_instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm_d)
    );

    // x0 reads as zero; a same-cycle writeback overrides the stale regfile data
    assign rs1_d = Read_Reg1 == '0 ? '0 : (wb_write && wb_reg == Read_Reg1) ? wb_data : Read_Data1;
    assign rs2_d = Read_Reg2 == '0 ? '0 : (wb_write && wb_reg == Read_Reg2) ? wb_data : Read_Data2;

    assign ld  = !id_valid_q | id_ready;
    assign haz = id_valid_q & ctrl_q.mem_rd & (id_rd_q != '0) &
                 ((uses_rs1 & id_rd_q == Read_Reg1) | (uses_rs2 & id_rd_q == Read_Reg2));
    assign if_ready = flush | (ld & !haz);
    assign capture  = ld & if_valid & !haz & !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            ctrl_q      <= '0;
            id_pc_q     <= '0;
            id_rs1_q    <= '0;
            id_rs2_q    <= '0;
            id_imm_q    <= '0;
            id_rd_q     <= '0;
            id_funct3_q <= '0;
        end else if (flush | ld) begin
            id_valid_q <= capture;
            ctrl_q     <= capture ? ctrl_d : '0;
            if (capture) begin
                id_pc_q     <= if_pc;
                id_rs1_q    <= rs1_d;
                id_rs2_q    <= rs2_d;
                id_imm_q    <= imm_d;
                id_rd_q     <= {1'b0, if_instr[11:7]};
                id_funct3_q <= f3;
            end
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_rs1_val     = id_rs1_q;
    assign id_rs2_val     = id_rs2_q;
    assign id_imm         = id_imm_q;
    assign id_rd          = id_rd_q;
    assign id_funct3      = id_funct3_q;
    assign id_rd_we       = ctrl_q.rd_we;
    assign id_alu_src_imm = ctrl_q.alu_src_imm;
    assign id_mem_rd      = ctrl_q.mem_rd;
    assign id_mem_wr      = ctrl_q.mem_wr;
    assign id_branch      = ctrl_q.branch;
    assign id_jump        = ctrl_q.jump;
    assign id_illegal     = ctrl_q.illegal;
    assign id_alu_op      = ctrl_q.alu_op;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage using hand-decoded RV32I vectors.
module tb_decode_stage;
    logic clk, rst, if_valid, if_ready, wb_write, flush, id_valid, id_ready;
    logic [31:0] if_instr, if_pc, Read_Data1, Read_Data2, wb_data;
    logic [5:0] Read_Reg1, Read_Reg2, wb_reg, id_rd;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic id_rd_we, id_alu_src_imm, id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal;
    logic [3:0] id_alu_op;
    logic [2:0] id_funct3;
    logic dead;

    typedef struct packed {
        logic [31:0] pc, rs1, rs2, imm;
        logic [5:0]  rd;
        logic [6:0]  ctl;
        logic [3:0]  alu;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb[$];
    exp_t mon_a, mon_e;
    int checks = 0, errors = 0, ncyc = 0;
    bit vlog[0:4095];
    bit rlog[0:4095];

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
        .Read_Data1(Read_Data1), .Read_Data2(Read_Data2), .wb_write(wb_write), .wb_reg(wb_reg),
        .wb_data(wb_data), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_alu_src_imm(id_alu_src_imm),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_branch(id_branch), .id_jump(id_jump),
        .id_illegal(id_illegal), .id_alu_op(id_alu_op), .id_funct3(id_funct3)
    );

    // register file stand-in: xN holds 0x1000_00NN, or 0xDEAD everywhere in bypass test
    assign Read_Data1 = dead ? 32'hDEAD : 32'h1000_0000 | {26'b0, Read_Reg1};
    assign Read_Data2 = dead ? 32'hDEAD : 32'h1000_0000 | {26'b0, Read_Reg2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (ncyc < 4096) begin
            vlog[ncyc] = id_valid;
            rlog[ncyc] = if_ready;
        end
        ncyc++;
    end

    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            mon_a = {id_pc, id_rs1_val, id_rs2_val, id_imm, id_rd, id_rd_we, id_alu_src_imm,
                     id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal, id_alu_op, id_funct3};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output pc=%h got %h", id_pc, mon_a);
            end else begin
                mon_e = sb.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL item pc=%h got %h expected %h", mon_e.pc, mon_a, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, r1, r2, imm, input logic [5:0] rd,
                                input logic [6:0] ctl, input logic [3:0] alu, input logic [2:0] f3);
        return {pc, r1, r2, imm, rd, ctl, alu, f3};
    endfunction

    task automatic issue(input logic [31:0] ins, input exp_t e, output int idx);
        bit acc = 1'b0;
        idx = -1;
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = e.pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = if_ready;
            @(posedge clk);
        end
        if (acc) begin
            sb.push_back(e);
            idx = ncyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout pc=%h got not_accepted expected accepted", e.pc);
        end
        #1;
    endtask

    // ctl bits: rd_we, alu_src_imm, mem_rd, mem_wr, branch, jump, illegal
    logic [31:0] vi[10];
    exp_t ve[10];
    int ix[10];
    int t;
    exp_t e;

    initial begin
        vi[0] = 32'hFFF00293; ve[0] = mk(32'h100, 32'h0,        32'h1000001F, 32'hFFFFFFFF, 5,  7'b1100000, 0, 0);
        vi[1] = 32'h003180B3; ve[1] = mk(32'h104, 32'h1234,     32'h1234,     32'h3,        1,  7'b1000000, 0, 0);
        vi[2] = 32'h406283B3; ve[2] = mk(32'h108, 32'h10000005, 32'h10000006, 32'h406,      7,  7'b1000000, 1, 0);
        vi[3] = 32'h4034D413; ve[3] = mk(32'h10C, 32'h10000009, 32'h10000003, 32'h403,      8,  7'b1100000, 7, 5);
        vi[4] = 32'h0020C863; ve[4] = mk(32'h110, 32'h10000001, 32'h10000002, 32'h10,       16, 7'b0000100, 3, 4);
        vi[5] = 32'h00512423; ve[5] = mk(32'h114, 32'h10000002, 32'h10000005, 32'h8,        8,  7'b0101000, 0, 2);
        vi[6] = 32'h12345537; ve[6] = mk(32'h118, 32'h10000008, 32'h10000003, 32'h12345000, 10, 7'b1100000, 0, 5);
        vi[7] = 32'hFFDFF0EF; ve[7] = mk(32'h11C, 32'h1000001F, 32'h1000001D, 32'hFFFFFFFC, 1,  7'b1100010, 0, 7);
        vi[8] = 32'h0000A103; ve[8] = mk(32'h120, 32'h10000001, 32'h0,        32'h0,        2,  7'b1110000, 0, 2);
        vi[9] = 32'h002101B3; ve[9] = mk(32'h124, 32'h10000002, 32'h10000002, 32'h2,        3,  7'b1000000, 0, 0);
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b1; flush = 1'b0;
        wb_write = 1'b0; wb_reg = '0; wb_data = '0; dead = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", id_valid, 0);
        chk("reset_payload", {id_pc, id_imm}, 0);
        chk("reset_ctrl", {id_rd_we, id_mem_rd, id_mem_wr, id_branch, id_jump, id_illegal, id_rd}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", if_ready, 1);
        if_instr = vi[2];
        #1 chk("read_regs", {Read_Reg1, Read_Reg2}, {6'd5, 6'd6});
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin dead = 1'b1; wb_write = 1'b1; wb_reg = 6'd3; wb_data = 32'h1234; end
            issue(vi[i], ve[i], ix[i]);
            dead = 1'b0; wb_write = 1'b0;
        end
        if_valid = 1'b0;
        chk("throughput", ix[7] - ix[0], 7);
        repeat (3) @(posedge clk); #1;
        // load-use: lw x2 then add x3,x2,x2
        issue(vi[8], ve[8], ix[8]);
        issue(vi[9], ve[9], ix[9]);
        if_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("loaduse_valid_seq", {vlog[ix[8]], vlog[ix[8]+1], vlog[ix[8]+2]}, 3'b101);
        chk("loaduse_ready_seq", {rlog[ix[8]], rlog[ix[8]+1]}, 2'b01);
        // backpressure: sub held while srai is offered
        e = ve[2]; e.pc = 32'h130;
        issue(vi[2], e, t);
        id_ready = 1'b0; if_valid = 1'b1; if_instr = vi[3]; if_pc = 32'h134;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold", {id_valid, if_ready, id_pc, id_imm[29:0]}, {1'b1, 1'b0, 32'h130, 30'h406});
        end
        @(posedge clk); #1;
        id_ready = 1'b1;
        e = ve[3]; e.pc = 32'h134;
        issue(vi[3], e, t);
        if_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        // flush while a load-use hazard is pending and execute stalls
        e = ve[8]; e.pc = 32'h140;
        issue(vi[8], e, t);
        id_ready = 1'b0; if_valid = 1'b1; if_instr = vi[9]; if_pc = 32'h144; flush = 1'b1;
        @(negedge clk);
        chk("flush_wins", if_ready, 1);
        @(posedge clk); #1;
        flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_valid", id_valid, 0);
        @(negedge clk);
        chk("flush_dropped", id_valid, 0);
        @(posedge clk); #1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        e = mk(32'h150, 32'h1000001F, 32'h1000001F, 32'hFFFFFFFF, 31, 7'b0000001, 0, 7);
`else
        e = mk(32'h150, 32'h1000001F, 32'h1000001F, 32'hFFFFFFFF, 31, 7'b0000000, 0, 7);
`endif
        issue(32'hFFFFFFFF, e, t);
        if_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        // asynchronous reset in the middle of a stall
        e = ve[0]; e.pc = 32'h160;
        issue(vi[0], e, t);
        id_ready = 1'b0; if_valid = 1'b1; if_instr = vi[1]; if_pc = 32'h164;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_valid", id_valid, 0);
        chk("async_reset_payload", {id_pc, id_rd_we, id_rd}, 0);
        sb.delete();
        if_valid = 1'b0; id_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midreset", {if_ready, id_valid}, 2'b10);
        @(posedge clk); #1;
        e = ve[6]; e.pc = 32'h170;
        issue(vi[6], e, t);
        if_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
